// File: rtl/exec_muldiv_unit.sv
// -----------------------------------------------------------------------------
// exec_muldiv_unit
// Iterative RV32M multiply/divide unit for the Execute stage. One radix-2
// step per clock: shift-add multiply into a 2*WIDTH product, restoring divide.
// Divide-by-zero and signed overflow complete on a fast path straight to DONE.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - multiply leaves ITER as soon as the remaining
//                         multiplier bits are all zero (divide unaffected).
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous, active-high reset
//   FlushE  in   synchronous kill of the in-flight op
//   StartE  in   muldiv instruction present in E stage
//   OpE     in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   SrcAE   in   rs1 value (forwarded)
//   SrcBE   in   rs2 value (forwarded)
//   RdE     in   destination register tag
//   Busy    out  stall request to the hazard unit (combinational)
//   Done    out  one-cycle result-valid pulse (registered)
//   Result  out  result, holds until the next completion (registered)
//   RdOut   out  tag for Result (registered)
// -----------------------------------------------------------------------------
module exec_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlushE,
  input  logic             StartE,
  input  logic [2:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [4:0]       RdE,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RdOut
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned TAG_W  = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2:0]         op_q,     op_d;
  logic [TAG_W-1:0]   rd_q,     rd_d;
  logic               neg_q,    neg_d;
  logic [PROD_W-1:0]  acc_q,    acc_d;     // product, or {remainder, quotient}
  logic [PROD_W-1:0]  mcand_q,  mcand_d;   // shifted multiplicand
  logic [WIDTH-1:0]   opb_q,    opb_d;     // multiplier (shifting) or divisor
  logic [WIDTH-1:0]   result_q, result_d;
  logic [TAG_W-1:0]   rd_out_q, rd_out_d;
  logic               done_q,   done_d;

  // Operand decode at the accept edge
  logic             a_signed_c, b_signed_c;
  logic             sign_a_c, sign_b_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic             is_div_c, is_rem_c;
  logic             neg_c;
  logic             div_zero_c, div_ovf_c;
  logic [WIDTH-1:0] fast_res_c;

  always_comb begin
    a_signed_c = (OpE == OP_MUL) | (OpE == OP_MULH) | (OpE == OP_MULHSU) |
                 (OpE == OP_DIV) | (OpE == OP_REM);
    b_signed_c = (OpE == OP_MUL) | (OpE == OP_MULH) |
                 (OpE == OP_DIV) | (OpE == OP_REM);
    sign_a_c   = a_signed_c & SrcAE[WIDTH-1];
    sign_b_c   = b_signed_c & SrcBE[WIDTH-1];
    mag_a_c    = sign_a_c ? (~SrcAE + WIDTH'(1)) : SrcAE;
    mag_b_c    = sign_b_c ? (~SrcBE + WIDTH'(1)) : SrcBE;
    is_div_c   = OpE[2];
    is_rem_c   = OpE[2] & OpE[1];
    // Remainder takes the dividend's sign; product/quotient the XOR
    neg_c      = is_rem_c ? sign_a_c : (sign_a_c ^ sign_b_c);
    div_zero_c = is_div_c & (SrcBE == '0);
    div_ovf_c  = is_div_c & ~OpE[0] & (SrcAE == MIN_NEG) & (SrcBE == '1);
    if (div_zero_c) begin
      fast_res_c = is_rem_c ? SrcAE : '1;
    end else begin
      fast_res_c = is_rem_c ? '0 : MIN_NEG;
    end
  end

  // One iteration step for each algorithm
  logic [PROD_W-1:0] mul_next_c;
  logic [WIDTH:0]    div_trial_c;
  logic              div_ge_c;
  logic [WIDTH-1:0]  div_diff_c;
  logic [WIDTH-1:0]  div_rem_c;
  logic [PROD_W-1:0] div_next_c;

  always_comb begin
    mul_next_c  = acc_q + (opb_q[0] ? mcand_q : '0);
    // Remainder shifted left with the next dividend bit brought in
    div_trial_c = acc_q[PROD_W-1:WIDTH-1];
    div_ge_c    = div_trial_c >= {1'b0, opb_q};
    // True difference is below 2^WIDTH whenever it is used
    div_diff_c  = div_trial_c[WIDTH-1:0] - opb_q;
    div_rem_c   = div_ge_c ? div_diff_c : div_trial_c[WIDTH-1:0];
    div_next_c  = {div_rem_c, acc_q[WIDTH-2:0], div_ge_c};
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Bits still to be consumed after the one processed this edge
  logic mul_rest_zero_c;
  assign mul_rest_zero_c = (opb_q[WIDTH-1:1] == '0);
`endif

  // Sign fix-up and result selection
  logic [PROD_W-1:0] prod_fix_c;
  logic [WIDTH-1:0]  div_sel_c;
  logic [WIDTH-1:0]  div_fix_c;
  logic [WIDTH-1:0]  fix_res_c;

  always_comb begin
    prod_fix_c = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;
    div_sel_c  = op_q[1] ? acc_q[PROD_W-1:WIDTH] : acc_q[WIDTH-1:0];
    div_fix_c  = neg_q ? (~div_sel_c + WIDTH'(1)) : div_sel_c;
    if (op_q[2]) begin
      fix_res_c = div_fix_c;
    end else if (op_q == OP_MUL) begin
      fix_res_c = prod_fix_c[WIDTH-1:0];
    end else begin
      fix_res_c = prod_fix_c[PROD_W-1:WIDTH];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          op_d    = OpE;
          rd_d    = RdE;
          neg_d   = neg_c;
          cnt_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, mag_a_c};
          opb_d   = mag_b_c;
          acc_d   = is_div_c ? {{WIDTH{1'b0}}, mag_a_c} : '0;
          if (div_zero_c || div_ovf_c) begin
            result_d = fast_res_c;
            rd_out_d = RdE;
            state_d  = DONE;
`ifdef MULDIV_EARLY_OUT_EN
          end else if (!is_div_c && (mag_b_c == '0)) begin
            state_d = FIX;
`endif
          end else begin
            state_d = ITER;
          end
        end
      end

      ITER: begin
        if (FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            acc_d = div_next_c;
          end else begin
            acc_d   = mul_next_c;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
          end
`ifdef MULDIV_EARLY_OUT_EN
          if ((cnt_q == CNT_LAST) || (!op_q[2] && mul_rest_zero_c)) begin
            state_d = FIX;
          end
`else
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
`endif
        end
      end

      FIX: begin
        if (FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          result_d = fix_res_c;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end

      DONE: begin
        // Same instruction still sits in E, so StartE is not looked at
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  // Stall request; low in DONE so the pipeline advances on the edge ending it
  assign Busy   = ~rst & (((state_q == IDLE) & StartE & ~FlushE) |
                          (state_q == ITER) | (state_q == FIX));
  assign Done   = done_q;
  assign Result = result_q;
  assign RdOut  = rd_out_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_muldiv_unit
// Self-checking bench for exec_muldiv_unit: directed RV32M vectors, flush and
// reset scenarios, and randomized ops against an arithmetic reference model.
// Honors MULDIV_EARLY_OUT_EN for expected multiply latency.
// -----------------------------------------------------------------------------
module tb_exec_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        FlushE;
  logic        StartE;
  logic [2:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [4:0]  RdE;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [4:0]  RdOut;

  int checks = 0;
  int errors = 0;

  exec_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .FlushE (FlushE),
    .StartE (StartE),
    .OpE    (OpE),
    .SrcAE  (SrcAE),
    .SrcBE  (SrcBE),
    .RdE    (RdE),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .RdOut  (RdOut)
  );

  always #5 clk = ~clk;

  // RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Clock edges from the start cycle's negedge to the first negedge with Done
  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    int          lat;
    logic [31:0] mb;
    lat = 34;
    mb  = b;
    if (op[2]) begin
      if (b == 32'd0) lat = 1;
      else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
    end else begin
`ifdef MULDIV_EARLY_OUT_EN
      if (op <= 3'd1 && b[31]) mb = -b;
      lat = 2;
      for (int i = 0; i < 32; i++) if (mb[i]) lat = i + 3;
`else
      if (mb == 32'd0) lat = 34;
`endif
    end
    return lat;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 15));
      4:       v = 32'($urandom_range(0, 1000)) * 32'd3;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op the way the stalled pipeline would and check completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input string name);
    int         exp_lat, n;
    bit         got, busy_bad;
    logic [4:0] rd;
    rd      = 5'($urandom_range(1, 31));
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    #1;
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_start: got %b want 1", name, Busy);
    end
    n = 0; got = 0; busy_bad = 0;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (Done === 1'b1) got = 1;
      else if (Busy !== 1'b1) busy_bad = 1;
    end
    checks++;
    if (!got || n != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d (done=%b) want %0d", name, n, got, exp_lat);
    end
    checks++;
    if (busy_bad) begin
      errors++; $display("FAIL %s busy_iter: got 0 want 1 before Done", name);
    end
    checks++;
    if (Result !== exp_r) begin
      errors++; $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", name, op, a, b, Result, exp_r);
    end
    checks++;
    if (RdOut !== rd) begin
      errors++; $display("FAIL %s rdout: got %0d want %0d", name, RdOut, rd);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_done: got %b want 0", name, Busy);
    end
    // StartE still high across the edge ending DONE; it must not re-accept
    @(posedge clk); #1;
    StartE = 1'b0; OpE = 3'($urandom); SrcAE = $urandom; SrcBE = $urandom;
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, Done, Busy);
    end
    checks++;
    if (Result !== exp_r || RdOut !== rd) begin
      errors++; $display("FAIL %s hold: got %h/%0d want %h/%0d", name, Result, RdOut, exp_r, rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; FlushE = 1'b0; StartE = 1'b1; OpE = 3'd0;
    SrcAE = 32'd3; SrcBE = 32'd4; RdE = 5'd1;
    #3;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", Busy, Done);
    end
    checks++;
    if (Result !== 32'd0 || RdOut !== 5'd0) begin
      errors++; $display("FAIL reset_data: got %h/%0d want 0/0", Result, RdOut);
    end
    @(negedge clk);
    StartE = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        "divu_100_7");
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7");
    run_op(3'd4, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, "div_m100_7");
    run_op(3'd6, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, "rem_m100_7");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_op(3'd7, 32'd5,          32'd0,         32'd5,         "remu_by0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run_op(3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "rem_by0_neg");
    run_op(3'd0, 32'd1234,       32'd3,         32'd3702,      "mul_1234_3");
    run_op(3'd0, 32'h0BAD_CAFE,  32'd0,         32'd0,         "mul_by0");
  endtask

  task automatic test_flush();
    logic [31:0] prev_r;
    logic [4:0]  prev_rd;
    bit          seen;
    prev_r  = Result;
    prev_rd = RdOut;
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd3; RdE = 5'd9;
    repeat (10) @(negedge clk);   // E9 done; the next edge is the 10th ITER edge
    FlushE = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b want 0", Busy);
    end
    checks++;
    if (Result !== prev_r || RdOut !== prev_rd) begin
      errors++; $display("FAIL flush_result: got %h/%0d want %h/%0d", Result, RdOut, prev_r, prev_rd);
    end
    StartE = 1'b0; FlushE = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1 || Busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_no_done: got activity after flush want none");
    end

    // Flush together with StartE in IDLE must not accept
    StartE = 1'b1; FlushE = 1'b1; OpE = 3'd0; SrcAE = 32'd9; SrcBE = 32'd9;
    #1;
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy: got %b want 0", Busy);
    end
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL flush_idle_accept: got busy=%b done=%b want 0 0", Busy, Done);
    end

    // Flush during DONE still lets the Done pulse complete
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd5; SrcAE = 32'd5; SrcBE = 32'd0; RdE = 5'd4;
    @(negedge clk);
    FlushE = 1'b1;
    #1;
    checks++;
    if (Done !== 1'b1 || Result !== 32'hFFFF_FFFF || RdOut !== 5'd4) begin
      errors++; $display("FAIL flush_done: got done=%b %h/%0d want 1 ffffffff/4", Done, Result, RdOut);
    end
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL flush_done_idle: got done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd0; SrcAE = 32'h0001_2345; SrcBE = 32'h7FFF_0001; RdE = 5'd7;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd0 || RdOut !== 5'd0) begin
      errors++; $display("FAIL rst_mid: got busy=%b done=%b %h/%0d want 0 0 0/0", Busy, Done, Result, RdOut);
    end
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_mid_no_done: got Done after reset want none");
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ref_result(op, a, b), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
